blob_tracker: RTL and testbench
===============================

Name: blob_tracker

Overview:
- Pixel-stream analyser; the inverse of the on-screen sprite generators. Instead of drawing a rectangle at a given (x, y), it finds one in incoming video.
- Watches a scan-ordered pixel stream (camera or frame-buffer readout) with hcount/vcount coordinates.
- Classifies each pixel against a target colour and accumulates a bounding box over one frame.
- At end of frame, reports centre and half-size in the same x/y/radius format the box overlay consumes, so tracker output can drive the box overlay directly.

Parameters:
- H_ACTIVE, 320, active pixels per line; pixels with hcount_in >= H_ACTIVE are ignored.
- V_ACTIVE, 240, active lines per frame; pixels with vcount_in >= V_ACTIVE are ignored.
- MIN_PIXELS, 16, minimum matched-pixel count for found_out=1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  pixel_in/hcount_in/vcount_in are valid this cycle.
- hcount_in  input  11  pixel x coordinate.
- vcount_in  input  10  pixel y coordinate.
- pixel_in  input  12  RGB444 pixel, {R[11:8], G[7:4], B[3:0]}.
- target_in  input  12  RGB444 colour to track; sampled at start of frame.
- tol_in  input  4  per-channel tolerance; sampled at start of frame.
- x_out  output  11  bounding-box centre x.
- y_out  output  10  bounding-box centre y.
- radius_out  output  8  half of max(width, height), saturating at 255.
- count_out  output  17  matched pixels in the last completed frame.
- found_out  output  1  count_out >= MIN_PIXELS.
- frame_done_out  output  1  one-cycle pulse when the outputs update.

Behaviour:
Reset and output hold:
- Reset values: all outputs 0; FSM to WAIT_SOF; accumulators cleared; pipeline valid bits cleared.
- Outputs hold their values between frame_done_out pulses.

Events:
- SOF (start of frame): valid_in && hcount_in==0 && vcount_in==0.
- EOF (end of frame): valid_in && hcount_in==H_ACTIVE-1 && vcount_in==V_ACTIVE-1.

FSM:
- WAIT_SOF: ignore pixels until SOF. On SOF, latch target_in/tol_in, clear accumulators (xmin=2047, xmax=0, ymin=1023, ymax=0, count=0), go to ACCUM. The SOF pixel itself is classified.
- ACCUM: classify active pixels. On EOF go to REPORT.
- ACCUM, SOF seen again before EOF (truncated frame): discard the partial frame, re-latch target/tol, restart accumulation. Outputs are not updated and no pulse is produced.
- REPORT: one cycle after the last pixel has reached the accumulators. Update outputs, pulse frame_done_out, go to WAIT_SOF. An SOF arriving while in REPORT is honoured: restart accumulation as in WAIT_SOF.

Match rule:
- Match when |R-Rt|<=tol, |G-Gt|<=tol and |B-Bt|<=tol.
- Compute differences unsigned, 5-bit, no wrap.
- Only valid_in pixels inside the active area count.

Pipeline and latency:
- Stage 1 registers {match, hcount, vcount}.
- Stage 2 updates min/max/count.
- Last pixel accepted at cycle T; accumulators include it at T+2; outputs and frame_done_out at T+3.
- valid_in may drop at any cycle; bubbles do not disturb accumulation.

Arithmetic:
- count saturates at 2^17-1.
- x_out = (xmin+xmax)>>1, computed in 12 bits then truncated; y_out likewise.
- w = xmax-xmin+1, h = ymax-ymin+1; radius_out = min(255, max(w,h)>>1).
- Zero matches: found_out=0, count_out=0, x_out/y_out/radius_out hold their previous values.
- Found is based on count only; a box is reported even if it touches the frame edge.

Reset mid-frame:
- Partial frame discarded; outputs return to 0 in the next cycle; tracking restarts only at the next SOF.

Decomposition:
- Shared package chase_pkg holds: RGB444 channel-slice constants, typedef pixel_t (12-bit), coord_x_t (11), coord_y_t (10), and the tracker FSM enum state_t {WAIT_SOF, ACCUM, REPORT}.
- Sub-module color_match: combinational, pixel/target/tol in, match out. It is reused later for multi-target tracking.

Test Plan:
- Uniform black frame, target 12'hF00, tol 1 -> frame_done_out pulses once at EOF+3; found_out=0, count_out=0; x/y/radius keep reset value 0.
- Red 20x10 rectangle at x 100..119, y 50..59 on black, target F00, tol 0 -> count_out=200, x_out=109, y_out=54, radius_out=10, found_out=1.
- Same frame, pixel 12'hE11 inside the rectangle, tol 0 vs tol 1 -> that pixel is excluded (count 199) vs included (count 200).
- Rectangle 3x3 (9 pixels), MIN_PIXELS=16 -> count_out=9, found_out=0, x_out/y_out still the centre.
- Full-frame match, target=pixel, tol 15 -> count_out=76800, x_out=159, y_out=119, radius_out=min(255,320>>1)=160.
- rst_in asserted at line 100 of a matching frame, then a full matching frame -> outputs 0 right after reset, no pulse for the partial frame, correct report after the next complete frame. Also: SOF injected mid-frame -> no pulse until the restarted frame completes.

Source files
------------

// File: rtl/chase_pkg.sv
// Shared types for the pixel-stream tracking blocks: RGB444 channel slices,
// coordinate types and the tracker FSM encoding.
package chase_pkg;

    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

    typedef logic [11:0] pixel_t;
    typedef logic [10:0] coord_x_t;
    typedef logic [9:0]  coord_y_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACCUM,
        REPORT
    } state_t;

endpackage

// File: rtl/color_match.sv
// Combinational RGB444 colour classifier: match when every channel is within tol of target.
// Zero latency; no flow control.
module color_match
    import chase_pkg::*;
(
    input  pixel_t     pixel,
    input  pixel_t     target,
    input  logic [3:0] tol,
    output logic       match
);

    // Differences are formed as magnitudes so they never wrap.
    function automatic logic [4:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {1'b0, d};
    endfunction

    logic [4:0] diff_r;
    logic [4:0] diff_g;
    logic [4:0] diff_b;

    always_comb begin
        diff_r = abs_diff(pixel[R_HI:R_LO], target[R_HI:R_LO]);
        diff_g = abs_diff(pixel[G_HI:G_LO], target[G_HI:G_LO]);
        diff_b = abs_diff(pixel[B_HI:B_LO], target[B_HI:B_LO]);
        match  = (diff_r <= {1'b0, tol}) && (diff_g <= {1'b0, tol}) && (diff_b <= {1'b0, tol});
    end

endmodule

// File: rtl/blob_tracker.sv
// Finds the bounding box of target-coloured pixels in one frame and reports centre/half-size.
// Outputs update 3 cycles after the EOF pixel; input may bubble freely, there is no backpressure.
module blob_tracker
    import chase_pkg::*;
#(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [11:0] pixel_in,
    input  logic [11:0] target_in,
    input  logic [3:0]  tol_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [7:0]  radius_out,
    output logic [16:0] count_out,
    output logic        found_out,
    output logic        frame_done_out
);

    localparam coord_x_t    H_LAST    = coord_x_t'(H_ACTIVE - 1);
    localparam coord_y_t    V_LAST    = coord_y_t'(V_ACTIVE - 1);
    localparam logic [16:0] COUNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic       clear;
    logic       report;

    pixel_t     target_q;
    logic [3:0] tol_q;
    logic       pix_match;
    logic       sof;
    logic       eof;
    logic       active;

    logic       s1_match;
    logic       s1_eof;
    coord_x_t   s1_h;
    coord_y_t   s1_v;

    coord_x_t    xmin;
    coord_x_t    xmax;
    coord_y_t    ymin;
    coord_y_t    ymax;
    logic [16:0] count;

    logic [11:0] x_sum;
    logic [10:0] y_sum;
    logic [11:0] width;
    logic [11:0] height;
    logic [11:0] span;
    logic [10:0] half;

    always_comb begin
        sof    = valid_in && (hcount_in == '0) && (vcount_in == '0);
        eof    = valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
        active = (int'(hcount_in) < H_ACTIVE) && (int'(vcount_in) < V_ACTIVE);
    end

    // The SOF pixel is classified against the target it is latching, not the stale one.
    color_match u_match (
        .pixel  (pixel_in),
        .target (sof ? target_in : target_q),
        .tol    (sof ? tol_in : tol_q),
        .match  (pix_match)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= WAIT_SOF;
            target_q <= '0;
            tol_q    <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                target_q <= target_in;
                tol_q    <= tol_in;
            end
        end
    end

    // Any SOF restarts accumulation, including one that truncates a frame in progress.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        report    = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                if (sof) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (sof) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end else if (s1_eof) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                report    = 1'b1;
                state_nxt = WAIT_SOF;
                if (sof) begin
                    clear     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_match <= 1'b0;
            s1_eof   <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
        end else begin
            s1_match <= valid_in && active && pix_match;
            s1_eof   <= eof && (state == ACCUM) && !sof;
            s1_h     <= hcount_in;
            s1_v     <= vcount_in;
        end
    end

    // Stage 1 may hold a pixel from before SOF; the clear on SOF discards it.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            xmin  <= '1;
            xmax  <= '0;
            ymin  <= '1;
            ymax  <= '0;
            count <= '0;
        end else if ((state == ACCUM) && s1_match) begin
            if (s1_h < xmin) xmin <= s1_h;
            if (s1_h > xmax) xmax <= s1_h;
            if (s1_v < ymin) ymin <= s1_v;
            if (s1_v > ymax) ymax <= s1_v;
            if (count != COUNT_MAX) count <= count + 17'd1;
        end
    end

    always_comb begin
        x_sum  = {1'b0, xmin} + {1'b0, xmax};
        y_sum  = {1'b0, ymin} + {1'b0, ymax};
        width  = {1'b0, xmax} - {1'b0, xmin} + 12'd1;
        height = {2'b00, ymax} - {2'b00, ymin} + 12'd1;
        span   = (width > height) ? width : height;
        half   = span[11:1];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_out          <= '0;
            y_out          <= '0;
            radius_out     <= '0;
            count_out      <= '0;
            found_out      <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= report;
            if (report) begin
                count_out <= count;
                found_out <= (count >= 17'(MIN_PIXELS));
                // An empty frame has no box, so the previous geometry is kept.
                if (count != '0) begin
                    x_out      <= x_sum[11:1];
                    y_out      <= y_sum[10:1];
                    radius_out <= (half > 11'd255) ? 8'd255 : half[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_blob_tracker.sv
// Directed bench for blob_tracker: table of sparse frames plus truncated-frame,
// mid-frame reset and full-frame sequences.
module tb_blob_tracker;

    localparam int H = 320;
    localparam int V = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [11:0] pix;
    logic [11:0] target;
    logic [3:0]  tol;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [7:0]  radius_out;
    logic [16:0] count_out;
    logic        found_out;
    logic        frame_done_out;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    typedef struct {
        int x0, x1, y0, y1;
        int col, tgt, tl;
        int sx, sy, scol;
        int e_count, e_x, e_y, e_r, e_found;
    } vec_t;

    vec_t tbl [7];

    blob_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(16)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .valid_in       (valid),
        .hcount_in      (hc),
        .vcount_in      (vc),
        .pixel_in       (pix),
        .target_in      (target),
        .tol_in         (tol),
        .x_out          (x_out),
        .y_out          (y_out),
        .radius_out     (radius_out),
        .count_out      (count_out),
        .found_out      (found_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done_out) pulses++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int x, input int y, input int p);
        valid = v;
        hc    = 11'(x);
        vc    = 10'(y);
        pix   = 12'(p);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    // Called in the cycle after the EOF pixel; n is the cycle offset from EOF.
    task automatic wait_pulse(output int n);
        n = 1;
        valid = 1'b0;
        while (!frame_done_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_report(input string tag, input int n, input int e_count,
                                input int e_x, input int e_y, input int e_r, input int e_found);
        chk({tag, " latency"}, n, 3);
        chk({tag, " count"}, int'(count_out), e_count);
        chk({tag, " x"}, int'(x_out), e_x);
        chk({tag, " y"}, int'(y_out), e_y);
        chk({tag, " radius"}, int'(radius_out), e_r);
        chk({tag, " found"}, int'(found_out), e_found);
        idle(1);
        chk({tag, " pulse width"}, int'(frame_done_out), 0);
    endtask

    task automatic send_frame(input vec_t v);
        int k = 0;
        target = 12'(v.tgt);
        tol    = 4'(v.tl);
        drive(1'b1, 0, 0, 0);
        target = ~12'(v.tgt);
        tol    = 4'd0;
        for (int y = v.y0; y <= v.y1; y++) begin
            for (int x = v.x0; x <= v.x1; x++) begin
                drive(1'b1, x, y, (x == v.sx && y == v.sy) ? v.scol : v.col);
                k++;
                if (k % 3 == 0) drive(1'b0, 1, 1, v.col);
            end
        end
        drive(1'b1, H, 5, v.col);
        drive(1'b1, 5, V, v.col);
        drive(1'b1, H - 1, V - 1, 0);
    endtask

    initial begin
        int n;
        int p0;

        tbl[0] = '{1, 0, 1, 0, 'h000, 'hF00, 1, 2047, 1023, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{100, 119, 50, 59, 'hF00, 'hF00, 0, 2047, 1023, 0, 200, 109, 54, 10, 1};
        tbl[2] = '{100, 119, 50, 59, 'hF00, 'hF00, 0, 105, 55, 'hE11, 199, 109, 54, 10, 1};
        tbl[3] = '{100, 119, 50, 59, 'hF00, 'hF00, 1, 105, 55, 'hE11, 200, 109, 54, 10, 1};
        tbl[4] = '{10, 12, 20, 22, 'h0F0, 'h0F0, 0, 2047, 1023, 0, 9, 11, 21, 1, 0};
        tbl[5] = '{1, 0, 1, 0, 'h000, 'hF00, 1, 2047, 1023, 0, 0, 11, 21, 1, 0};
        tbl[6] = '{300, 319, 220, 229, 'h00F, 'h00E, 1, 2047, 1023, 0, 200, 309, 224, 10, 1};

        rst = 1'b1; valid = 1'b0; hc = '0; vc = '0; pix = '0; target = '0; tol = '0;
        idle(3);
        chk("reset count", int'(count_out), 0);
        chk("reset x", int'(x_out), 0);
        chk("reset y", int'(y_out), 0);
        chk("reset radius", int'(radius_out), 0);
        chk("reset found", int'(found_out), 0);
        chk("reset pulse", int'(frame_done_out), 0);
        rst = 1'b0;

        // Matching pixels before any SOF must not be accumulated.
        target = 12'hF00; tol = 4'd0;
        for (int i = 0; i < 5; i++) drive(1'b1, 100 + i, 50, 'hF00);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i]);
            wait_pulse(n);
            check_report($sformatf("vec%0d", i), n, tbl[i].e_count, tbl[i].e_x,
                         tbl[i].e_y, tbl[i].e_r, tbl[i].e_found);
        end

        // Truncated frame: the 2x2 block before the second SOF is discarded.
        p0 = pulses;
        target = 12'h0F0; tol = 4'd0;
        drive(1'b1, 0, 0, 0);
        for (int y = 10; y <= 11; y++) for (int x = 50; x <= 51; x++) drive(1'b1, x, y, 'h0F0);
        drive(1'b1, 0, 0, 0);
        for (int y = 40; y <= 43; y++) for (int x = 30; x <= 33; x++) drive(1'b1, x, y, 'h0F0);
        chk("resof no pulse", pulses - p0, 0);
        drive(1'b1, H - 1, V - 1, 0);
        wait_pulse(n);
        check_report("resof", n, 16, 31, 41, 2, 1);

        // Reset partway through a matching frame.
        target = 12'hF00; tol = 4'd0;
        drive(1'b1, 0, 0, 'hF00);
        for (int y = 1; y <= 100; y++) drive(1'b1, 10, y, 'hF00);
        rst = 1'b1;
        idle(1);
        chk("midrst count", int'(count_out), 0);
        chk("midrst x", int'(x_out), 0);
        chk("midrst y", int'(y_out), 0);
        chk("midrst radius", int'(radius_out), 0);
        chk("midrst found", int'(found_out), 0);
        rst = 1'b0;
        p0 = pulses;
        idle(5);
        drive(1'b1, H - 1, V - 1, 'hF00);
        idle(6);
        chk("midrst no pulse", pulses - p0, 0);

        // Full matching frame.
        target = 12'h5A5; tol = 4'd15;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                drive(1'b1, x, y, {x[3:0], y[3:0], x[7:4] ^ y[7:4]});
            end
        end
        wait_pulse(n);
        check_report("full", n, 76800, 159, 119, 160, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
